// File: rtl/valve_pkg.sv
// Shared FSM state encoding and default parameter values for the valve sequencer.
package valve_pkg;

  // Per-channel sequencer states.
  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StWait = 2'd1;
  localparam state_t StOpen = 2'd2;
  localparam state_t StGap  = 2'd3;

  // Default parameter values for the top level.
  localparam int unsigned DefNumCh     = 4;
  localparam int unsigned DefLenW      = 24;
  localparam int unsigned DefRepW      = 4;
  localparam bit          DefExclusive = 1'b0;

endpackage

// File: rtl/multi_valve_sequencer_if.sv
// Control/status bundle between a host and the multi-valve sequencer.
interface multi_valve_sequencer_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned LEN_W  = 24,
  parameter int unsigned REP_W  = 4
);

  logic [NUM_CH-1:0]       trig;
  logic                    trig_all;
  logic                    abort;
  logic [NUM_CH*LEN_W-1:0] pulse_len;
  logic [NUM_CH*LEN_W-1:0] gap_len;
  logic [NUM_CH*REP_W-1:0] rep_count;
  logic [NUM_CH-1:0]       valve;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       done;

  // Host side: issues starts and timing, observes valve state.
  modport master (
    output trig, trig_all, abort, pulse_len, gap_len, rep_count,
    input  valve, busy, done
  );

  // Sequencer side.
  modport slave (
    input  trig, trig_all, abort, pulse_len, gap_len, rep_count,
    output valve, busy, done
  );

endinterface

// File: rtl/valve_channel.sv
// One valve channel: latches its timing on start and plays out
// N open/gap repeats, optionally waiting for an exclusive-use grant.
module valve_channel
  import valve_pkg::*;
#(
  parameter int unsigned LEN_W     = DefLenW,
  parameter int unsigned REP_W     = DefRepW,
  parameter bit          EXCLUSIVE = DefExclusive
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             grant,
  input  logic [LEN_W-1:0] pulse_len,
  input  logic [LEN_W-1:0] gap_len,
  input  logic [REP_W-1:0] rep_count,
  output logic             valve,
  output logic             busy,
  output logic             done,
  output logic             waiting,
  output logic             holding
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] plen_q, plen_d;
  logic [LEN_W-1:0] glen_q, glen_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic [REP_W-1:0] pcnt_q, pcnt_d;
  logic             valve_q, valve_d;
  logic             done_q, done_d;

  // Next-state: cnt counts cycles spent in the current phase starting at 1,
  // pcnt counts pulses started starting at 1.
  always_comb begin
    state_d = state_q;
    plen_d  = plen_q;
    glen_d  = glen_q;
    cnt_d   = cnt_q;
    reps_d  = reps_q;
    pcnt_d  = pcnt_q;
    valve_d = 1'b0;
    done_d  = 1'b0;

    if (abort) begin
      state_d = StIdle;
      cnt_d   = '0;
      pcnt_d  = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            plen_d = pulse_len;
            glen_d = gap_len;
            reps_d = (rep_count == '0) ? REP_W'(1) : rep_count;
            pcnt_d = REP_W'(1);
            cnt_d  = LEN_W'(1);
            if (pulse_len == '0) begin
              // Zero-length pulse completes immediately without opening.
              done_d = 1'b1;
            end else if (EXCLUSIVE) begin
              state_d = StWait;
            end else begin
              state_d = StOpen;
              valve_d = 1'b1;
            end
          end
        end

        StWait: begin
          if (grant) begin
            state_d = StOpen;
            valve_d = 1'b1;
            cnt_d   = LEN_W'(1);
          end
        end

        StOpen: begin
          if (cnt_q == plen_q) begin
            cnt_d = LEN_W'(1);
            if (pcnt_q == reps_q) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              state_d = StGap;
              pcnt_d  = pcnt_q + REP_W'(1);
            end
          end else begin
            cnt_d   = cnt_q + LEN_W'(1);
            valve_d = 1'b1;
          end
        end

        StGap: begin
          // gap_len of 0 still yields one closed cycle.
          if (cnt_q >= glen_q) begin
            state_d = StOpen;
            valve_d = 1'b1;
            cnt_d   = LEN_W'(1);
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State, counters and latched timing registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      plen_q  <= '0;
      glen_q  <= '0;
      cnt_q   <= '0;
      reps_q  <= '0;
      pcnt_q  <= '0;
      valve_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      plen_q  <= plen_d;
      glen_q  <= glen_d;
      cnt_q   <= cnt_d;
      reps_q  <= reps_d;
      pcnt_q  <= pcnt_d;
      valve_q <= valve_d;
      done_q  <= done_d;
    end
  end

  assign valve   = valve_q;
  assign done    = done_q;
  assign busy    = (state_q != StIdle);
  assign waiting = (state_q == StWait);
  // Holding the exclusive token covers the whole sequence, gaps included.
  assign holding = (state_q == StOpen) || (state_q == StGap);

endmodule

// File: rtl/multi_valve_sequencer.sv
// Multi-channel valve pulse sequencer: one valve_channel per output plus
// a fixed-priority token arbiter used when channels must not overlap.
module multi_valve_sequencer
  import valve_pkg::*;
#(
  parameter int unsigned NUM_CH    = DefNumCh,
  parameter int unsigned LEN_W     = DefLenW,
  parameter int unsigned REP_W     = DefRepW,
  parameter bit          EXCLUSIVE = DefExclusive
) (
  input logic                    clk,
  input logic                    reset,
  multi_valve_sequencer_if.slave bus
);

  logic [NUM_CH-1:0] waiting;
  logic [NUM_CH-1:0] holding;
  logic [NUM_CH-1:0] grant;
  logic              token_free;

  // Token is free whenever nobody is mid-sequence; derived from channel
  // state so a returning channel frees it in the same cycle it goes idle.
  assign token_free = ~|holding;

  // Hand a free token to the lowest-index waiting channel.
  always_comb begin
    grant = '0;
    if (EXCLUSIVE && token_free) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (waiting[i] && (grant == '0)) begin
          grant[i] = 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic start;

    assign start = bus.trig[i] | bus.trig_all;

    valve_channel #(
      .LEN_W     (LEN_W),
      .REP_W     (REP_W),
      .EXCLUSIVE (EXCLUSIVE)
    ) u_channel (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (bus.abort),
      .grant     (grant[i]),
      .pulse_len (bus.pulse_len[i*LEN_W +: LEN_W]),
      .gap_len   (bus.gap_len[i*LEN_W +: LEN_W]),
      .rep_count (bus.rep_count[i*REP_W +: REP_W]),
      .valve     (bus.valve[i]),
      .busy      (bus.busy[i]),
      .done      (bus.done[i]),
      .waiting   (waiting[i]),
      .holding   (holding[i])
    );
  end

endmodule

// File: tb/tb_multi_valve_sequencer.sv
// Directed bench for multi_valve_sequencer: free-running, exclusive and
// narrow-counter instances driven with hand-computed expected patterns.
module tb_multi_valve_sequencer;

  logic clk;
  logic reset;

  int n_checks;
  int n_pass;

  multi_valve_sequencer_if #(.NUM_CH(4), .LEN_W(24), .REP_W(4)) bus_a ();
  multi_valve_sequencer_if #(.NUM_CH(4), .LEN_W(24), .REP_W(4)) bus_b ();
  multi_valve_sequencer_if #(.NUM_CH(1), .LEN_W(3),  .REP_W(2)) bus_c ();

  multi_valve_sequencer #(.NUM_CH(4), .LEN_W(24), .REP_W(4), .EXCLUSIVE(1'b0)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  multi_valve_sequencer #(.NUM_CH(4), .LEN_W(24), .REP_W(4), .EXCLUSIVE(1'b1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  multi_valve_sequencer #(.NUM_CH(1), .LEN_W(3), .REP_W(2), .EXCLUSIVE(1'b0)) dut_c (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_a.trig = '0; bus_a.trig_all = 1'b0; bus_a.abort = 1'b0;
    bus_a.pulse_len = '0; bus_a.gap_len = '0; bus_a.rep_count = '0;
    bus_b.trig = '0; bus_b.trig_all = 1'b0; bus_b.abort = 1'b0;
    bus_b.pulse_len = '0; bus_b.gap_len = '0; bus_b.rep_count = '0;
    bus_c.trig = '0; bus_c.trig_all = 1'b0; bus_c.abort = 1'b0;
    bus_c.pulse_len = '0; bus_c.gap_len = '0; bus_c.rep_count = '0;
  endtask

  logic [31:0] v0, v1, v2, v3, d0, d1, d2, d3, b0;
  logic [31:0] vb [4];
  logic [31:0] db0, db3, bb3;
  int          overlap;
  logic [3:0]  busy_pre, busy_post, valve_post, done_or;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    clear_inputs();
    step();
    step();
    check("rst_valve_a", bus_a.valve, 0);
    check("rst_busy_a",  bus_a.busy,  0);
    check("rst_done_a",  bus_a.done,  0);
    check("rst_valve_b", bus_b.valve, 0);
    check("rst_busy_b",  bus_b.busy,  0);
    check("rst_done_b",  bus_b.done,  0);
    reset = 1'b0;
    step();

    // 5H,2L x3 on ch0; inputs scrambled after start must not matter.
    bus_a.pulse_len[23:0] = 24'd5;
    bus_a.gap_len[23:0]   = 24'd2;
    bus_a.rep_count[3:0]  = 4'd3;
    bus_a.trig = 4'b0001;
    step();
    bus_a.trig = 4'b0000;
    bus_a.pulse_len[23:0] = 24'd1;
    bus_a.gap_len[23:0]   = 24'd7;
    bus_a.rep_count[3:0]  = 4'd1;
    v0 = '0; d0 = '0; b0 = '0;
    for (int j = 0; j < 24; j++) begin
      v0[j] = bus_a.valve[0];
      d0[j] = bus_a.done[0];
      b0[j] = bus_a.busy[0];
      step();
    end
    check("t1_valve0", v0, 32'h0007_CF9F);
    check("t1_done0",  d0, 32'h0008_0000);
    check("t1_busy0",  b0, 32'h0007_FFFF);
    clear_inputs();
    step();

    // Exclusive mode: trig_all serialises ch0..ch3.
    for (int c = 0; c < 4; c++) begin
      bus_b.pulse_len[c*24 +: 24] = 24'd3;
      bus_b.rep_count[c*4 +: 4]   = 4'd1;
      vb[c] = '0;
    end
    bus_b.trig_all = 1'b1;
    step();
    bus_b.trig_all = 1'b0;
    db0 = '0; db3 = '0; bb3 = '0; overlap = 0;
    for (int j = 0; j < 20; j++) begin
      for (int c = 0; c < 4; c++) vb[c][j] = bus_b.valve[c];
      db0[j] = bus_b.done[0];
      db3[j] = bus_b.done[3];
      bb3[j] = bus_b.busy[3];
      if ($countones(bus_b.valve) > 1) overlap++;
      step();
    end
    check("t2_valve0",  vb[0], 32'h0000_000E);
    check("t2_valve1",  vb[1], 32'h0000_00E0);
    check("t2_valve2",  vb[2], 32'h0000_0E00);
    check("t2_valve3",  vb[3], 32'h0000_E000);
    check("t2_overlap", overlap, 0);
    check("t2_done0",   db0, 32'h0000_0010);
    check("t2_done3",   db3, 32'h0001_0000);
    check("t2_busy3",   bb3, 32'h0000_FFFF);
    clear_inputs();
    step();

    // gap_len=0 on ch0, retrigger of ch1 while open, zero-length pulse on ch2.
    bus_a.pulse_len[0 +: 24]  = 24'd2;
    bus_a.rep_count[0 +: 4]   = 4'd2;
    bus_a.gap_len[0 +: 24]    = 24'd0;
    bus_a.pulse_len[24 +: 24] = 24'd4;
    bus_a.rep_count[4 +: 4]   = 4'd2;
    bus_a.gap_len[24 +: 24]   = 24'd1;
    bus_a.pulse_len[48 +: 24] = 24'd0;
    bus_a.rep_count[8 +: 4]   = 4'd1;
    bus_a.trig = 4'b0011;
    step();
    bus_a.trig = 4'b0000;
    v0 = '0; v1 = '0; v2 = '0; d0 = '0; d1 = '0; d2 = '0;
    for (int j = 0; j < 12; j++) begin
      v0[j] = bus_a.valve[0]; d0[j] = bus_a.done[0];
      v1[j] = bus_a.valve[1]; d1[j] = bus_a.done[1];
      v2[j] = bus_a.valve[2]; d2[j] = bus_a.done[2];
      bus_a.trig = (j == 1) ? 4'b0110 : 4'b0000;
      step();
    end
    bus_a.trig = 4'b0000;
    check("t3_valve0", v0, 32'h0000_001B);
    check("t3_done0",  d0, 32'h0000_0020);
    check("t3_valve1", v1, 32'h0000_01EF);
    check("t3_done1",  d1, 32'h0000_0200);
    check("t3_valve2", v2, 32'h0000_0000);
    check("t3_done2",  d2, 32'h0000_0004);
    clear_inputs();
    step();

    // Abort mid-gap with ch3 waiting for the token.
    bus_b.pulse_len[0 +: 24]  = 24'd3;
    bus_b.rep_count[0 +: 4]   = 4'd2;
    bus_b.gap_len[0 +: 24]    = 24'd4;
    bus_b.pulse_len[72 +: 24] = 24'd2;
    bus_b.rep_count[12 +: 4]  = 4'd1;
    bus_b.trig = 4'b1001;
    step();
    bus_b.trig = 4'b0000;
    busy_pre = '0; busy_post = '1; valve_post = '1; done_or = '0;
    for (int j = 0; j < 10; j++) begin
      if (j == 5) busy_pre = bus_b.busy;
      if (j == 6) begin
        busy_post  = bus_b.busy;
        valve_post = bus_b.valve;
      end
      done_or = done_or | bus_b.done;
      bus_b.abort = (j == 5);
      step();
    end
    bus_b.abort = 1'b0;
    check("t4_busy_pre",   busy_pre,   4'b1001);
    check("t4_busy_post",  busy_post,  4'b0000);
    check("t4_valve_post", valve_post, 4'b0000);
    check("t4_no_done",    done_or,    4'b0000);
    bus_b.trig = 4'b1000;
    step();
    bus_b.trig = 4'b0000;
    v3 = '0; d3 = '0;
    for (int j = 0; j < 6; j++) begin
      v3[j] = bus_b.valve[3];
      d3[j] = bus_b.done[3];
      step();
    end
    check("t4_valve3", v3, 32'h0000_0006);
    check("t4_done3",  d3, 32'h0000_0008);
    clear_inputs();
    step();

    // Asynchronous reset between edges while open.
    bus_a.pulse_len[23:0] = 24'd10;
    bus_a.rep_count[3:0]  = 4'd1;
    bus_a.trig = 4'b0001;
    step();
    bus_a.trig = 4'b0000;
    step();
    step();
    check("t5_valve_pre", bus_a.valve, 4'b0001);
    #2 reset = 1'b1;
    #1;
    check("t5_valve_rst", bus_a.valve, 4'b0000);
    check("t5_busy_rst",  bus_a.busy,  4'b0000);
    #2 reset = 1'b0;
    step();
    bus_a.pulse_len[23:0] = 24'd2;
    bus_a.trig = 4'b0001;
    step();
    bus_a.trig = 4'b0000;
    v0 = '0; d0 = '0;
    for (int j = 0; j < 5; j++) begin
      v0[j] = bus_a.valve[0];
      d0[j] = bus_a.done[0];
      step();
    end
    check("t5_valve0", v0, 32'h0000_0003);
    check("t5_done0",  d0, 32'h0000_0004);
    clear_inputs();
    step();

    // Maximum pulse/gap on a 3-bit counter; rep_count=0 runs one pulse.
    bus_c.pulse_len = 3'd7;
    bus_c.gap_len   = 3'd7;
    bus_c.rep_count = 2'd2;
    bus_c.trig = 1'b1;
    step();
    bus_c.trig = 1'b0;
    v0 = '0; d0 = '0;
    for (int j = 0; j < 24; j++) begin
      v0[j] = bus_c.valve[0];
      d0[j] = bus_c.done[0];
      step();
    end
    check("t6_valve_max", v0, 32'h001F_C07F);
    check("t6_done_max",  d0, 32'h0020_0000);
    bus_c.rep_count = 2'd0;
    bus_c.trig = 1'b1;
    step();
    bus_c.trig = 1'b0;
    v0 = '0; d0 = '0;
    for (int j = 0; j < 10; j++) begin
      v0[j] = bus_c.valve[0];
      d0[j] = bus_c.done[0];
      step();
    end
    check("t6_valve_rep0", v0, 32'h0000_007F);
    check("t6_done_rep0",  d0, 32'h0000_0080);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_valve_sequencer.md
MULTI_VALVE_SEQUENCER -- requirements
Module: multi_valve_sequencer

Interface
REQ-001 Parameters SHALL be: NUM_CH, default 4, number of valve channels; LEN_W, default 24, pulse/gap counter width in clk cycles; REP_W, default 4, repeat-count width; EXCLUSIVE, default 0, 1 = at most one channel active at a time.
REP-002 The block has one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  system clock (1 MHz domain); all logic on posedge.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 trig  in  NUM_CH  per-channel single-cycle start pulse.
REQ-006 trig_all  in  1  single-cycle start pulse applied to every channel.
REQ-007 abort  in  1  level; forces all channels to IDLE.
REQ-008 pulse_len  in  NUM_CH*LEN_W  per-channel open time in cycles; channel i occupies slice [i*LEN_W +: LEN_W].
REQ-009 gap_len  in  NUM_CH*LEN_W  per-channel closed time between repeats in cycles.
REQ-010 rep_count  in  NUM_CH*REP_W  per-channel pulse count.
REQ-011 valve  out  NUM_CH  valve drive, active-high, registered.
REQ-012 busy  out  NUM_CH  high while channel is not IDLE.
REQ-013 done  out  NUM_CH  one-cycle pulse when a channel returns to IDLE normally.

Function
REQ-014 Each channel SHALL run an FSM with the states IDLE, WAIT, OPEN and GAP.
REQ-015 Start_i = trig[i] | trig_all, sampled on posedge clk; start is honoured only in IDLE and is ignored in WAIT/OPEN/GAP (no queueing of retriggers).
REQ-016 On an accepted start, pulse_len, gap_len and rep_count for that channel SHALL be latched; later input changes do not affect the running sequence.
REQ-017 Effective pulse count N = rep_count, with rep_count=0 treated as N=1.
REQ-018 Latched pulse_len=0: the channel SHALL go IDLE -> IDLE, keep valve low, and assert done on the cycle after start.
REQ-019 With EXCLUSIVE=0: IDLE -> OPEN on start; valve rises on the first clk edge after the start is sampled (1-cycle latency).
REQ-020 OPEN: valve high for exactly pulse_len cycles; afterwards, if pulses remain -> GAP, else -> IDLE with done=1 for one cycle.
REQ-021 GAP: valve low for exactly gap_len cycles, then -> OPEN; gap_len=0 gives a 1-cycle low between pulses (no merged pulses).
REQ-022 With EXCLUSIVE=1: IDLE -> WAIT on start; a channel leaves WAIT for OPEN only when granted.
REQ-023 The grant token SHALL be free when no channel is in OPEN or GAP; a free token is granted to the lowest-index WAIT channel, which enters OPEN on the next cycle.
REQ-024 The token SHALL stay held through the whole sequence (all repeats) and be released on return to IDLE; the next grant may issue in that same cycle, so valves never overlap and there is 1 cycle of all-closed between channels.
REQ-025 trig_all with EXCLUSIVE=1 SHALL therefore serialise channels 0..NUM_CH-1 in index order.
REQ-026 abort SHALL take priority over start; while abort is high, all channels go to IDLE on the next edge, valve=0 and busy=0, with no done pulse.
REQ-027 Counters SHALL be LEN_W bits; a pulse_len or gap_len at its maximum value (2^LEN_W-1) runs the full count without wrap.

Reset
REQ-028 Asserting reset SHALL asynchronously force all FSMs to IDLE and clear all counters, latched parameters and the token.
REQ-029 Reset values SHALL be: valve=0, busy=0, done=0.
REQ-030 Reset mid-pulse SHALL close the valve immediately; the first start after deassertion SHALL behave as from power-up.

Structure
REQ-031 The FSM state encoding and the default parameter constants SHALL live in a shared package, valve_pkg.
REQ-032 The per-channel FSM and counters SHALL be one sub-module, valve_channel, instantiated NUM_CH times via generate; the arbiter stays in the top module.

Verification
REQ-033 EXCLUSIVE=0; ch0 pulse_len=5, rep=3, gap=2; one trig[0] -> valve0 pattern 5H,2L,5H,2L,5H; done0 exactly 1 cycle after the last high; busy0 high for 19 cycles.
REQ-034 EXCLUSIVE=1; all pulse_len=3, rep=1; trig_all -> valve0,1,2,3 each high 3 cycles in order, 1 all-low cycle between them, never two valves high at once.
REQ-035 trig[1] re-pulsed during ch1 OPEN; and pulse_len=0 on ch2 -> ch1 sequence unchanged; ch2 valve stays 0, done2 on the next cycle.
REQ-036 abort raised mid-GAP with ch3 in WAIT -> all valve=0, busy=0 next edge, no done pulse; a later trig[3] starts normally.
REQ-037 Async reset asserted between clock edges during OPEN -> valve drops before the next edge; inputs changed after start -> the running sequence uses the latched values.
